// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the multi-cycle multiply sequencer.
// The MULX high-word ops are enabled by defining MUL_SEQ_MULX_EN.
package mul_seq_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CELL_W  = 16;
    localparam int unsigned PROD_W  = 2 * CELL_W;
    localparam int unsigned N_LO    = 3;
    localparam int unsigned N_HI    = 4;
    localparam int unsigned BEAT_W  = 2;
    localparam int unsigned SHAMT_W = 6;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXUU = 2'b01,
        OP_MULXSS = 2'b10,
        OP_MULXSU = 2'b11
    } op_e;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ACC   = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Accumulator shift for partial k: LL=0, LH/HL=16, HH=32.
    function automatic logic [SHAMT_W-1:0] beat_shift(input logic [BEAT_W-1:0] k);
        case (k)
            2'd0:    beat_shift = 6'd0;
            2'd3:    beat_shift = 6'd32;
            default: beat_shift = 6'd16;
        endcase
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_mul16_cell.sv
// Registered 16x16 unsigned multiply cell; output holds while en is low.
module mul16_cell
    import mul_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CELL_W-1:0] a,
    input  logic [CELL_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    logic [PROD_W-1:0] p_d;
    logic [PROD_W-1:0] p_q;

    always_comb begin
        p_d = p_q;
        if (en) begin
            p_d = PROD_W'(a) * PROD_W'(b);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle 32x32 multiply sequencer sharing one 16x16 cell across partial products.
// Define MUL_SEQ_MULX_EN to add MULXUU/MULXSS/MULXSU; otherwise every request is MUL.
module mul_seq_ctrl
    import mul_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              kill,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam logic [STATE_W-1:0] ST_IDLE  = S_IDLE;
    localparam logic [STATE_W-1:0] ST_ISSUE = S_ISSUE;
    localparam logic [STATE_W-1:0] ST_ACC   = S_ACC;
    localparam logic [STATE_W-1:0] ST_FIX   = S_FIX;
    localparam logic [STATE_W-1:0] ST_DONE  = S_DONE;

`ifdef MUL_SEQ_MULX_EN
    localparam int unsigned ACC_W = 2 * DATA_W;
`else
    localparam int unsigned ACC_W = DATA_W;
`endif

    logic [STATE_W-1:0] state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               pend_vld_q, pend_vld_d;
    logic [BEAT_W-1:0]  pend_beat_q, pend_beat_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DATA_W-1:0]  result_q, result_d;

    logic               cell_en_c;
    logic [CELL_W-1:0]  cell_a_c;
    logic [CELL_W-1:0]  cell_b_c;
    logic [PROD_W-1:0]  cell_p;
    logic [BEAT_W-1:0]  last_beat_c;
    logic [DATA_W-1:0]  fix_res_c;

`ifdef MUL_SEQ_MULX_EN
    logic [1:0]         op_q, op_d;
    logic [DATA_W-1:0]  hi_c;
    logic [DATA_W-1:0]  corr_a_c;
    logic [DATA_W-1:0]  corr_b_c;

    assign last_beat_c = (op_q == OP_MUL) ? BEAT_W'(N_LO - 1) : BEAT_W'(N_HI - 1);

    // High word of the unsigned product, corrected for signed operand interpretation.
    always_comb begin
        hi_c     = acc_q[2*DATA_W-1:DATA_W];
        corr_a_c = a_q[DATA_W-1] ? b_q : '0;
        corr_b_c = b_q[DATA_W-1] ? a_q : '0;
        case (op_q)
            OP_MULXUU: fix_res_c = hi_c;
            OP_MULXSS: fix_res_c = hi_c - corr_a_c - corr_b_c;
            OP_MULXSU: fix_res_c = hi_c - corr_a_c;
            default:   fix_res_c = acc_q[DATA_W-1:0];
        endcase
    end
`else
    logic               unused_op;

    assign unused_op   = ^op;
    assign last_beat_c = BEAT_W'(N_LO - 1);
    assign fix_res_c   = acc_q;
`endif

    // Beat k selects A half by k[1] and B half by k[0]: LL, LH, HL, HH.
    assign cell_a_c = beat_q[1] ? a_q[DATA_W-1:CELL_W] : a_q[CELL_W-1:0];
    assign cell_b_c = beat_q[0] ? b_q[DATA_W-1:CELL_W] : b_q[CELL_W-1:0];

    mul16_cell u_cell (
        .clk (clk),
        .rst (reset),
        .en  (cell_en_c),
        .a   (cell_a_c),
        .b   (cell_b_c),
        .p   (cell_p)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        pend_vld_d  = 1'b0;
        pend_beat_d = beat_q;
        result_d    = result_q;
        cell_en_c   = 1'b0;
`ifdef MUL_SEQ_MULX_EN
        op_d        = op_q;
`endif

        // The product registered last cycle lands in the accumulator this cycle.
        if (pend_vld_q) begin
            acc_d = acc_q + (ACC_W'(cell_p) << beat_shift(pend_beat_q));
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !kill) begin
                    a_d     = src1;
                    b_d     = src2;
                    acc_d   = '0;
                    beat_d  = '0;
                    state_d = ST_ISSUE;
`ifdef MUL_SEQ_MULX_EN
                    op_d    = op;
`endif
                end
            end
            ST_ISSUE: begin
                cell_en_c  = 1'b1;
                pend_vld_d = 1'b1;
                if (beat_q == last_beat_c) begin
                    state_d = ST_ACC;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            ST_ACC: begin
                state_d = ST_FIX;
            end
            ST_FIX: begin
                result_d = fix_res_c;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush abandons the operation without touching the visible result.
        if (kill && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            cell_en_c  = 1'b0;
            pend_vld_d = 1'b0;
            result_d   = result_q;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_beat_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
`ifdef MUL_SEQ_MULX_EN
            op_q        <= OP_MUL;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            pend_vld_q  <= pend_vld_d;
            pend_beat_q <= pend_beat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
`ifdef MUL_SEQ_MULX_EN
            op_q        <= op_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed vectors, kill/start/reset corners, random ops vs a 64-bit model.
module tb_mul_seq_ctrl;

`ifdef MUL_SEQ_MULX_EN
    localparam bit MULX = 1'b1;
`else
    localparam bit MULX = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_res = 32'h0;

    always #5 clk = ~clk;

    mul_seq_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_mulx;
        logic [31:0] exp_lo;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: full 64-bit product of the extended operands, then pick the word.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        logic [1:0]  eo;
        eo = MULX ? o : 2'b00;
        ea = {32'h0, a};
        eb = {32'h0, b};
        if (eo == 2'b10 || eo == 2'b11) ea = {{32{a[31]}}, a};
        if (eo == 2'b10) eb = {{32{b[31]}}, b};
        p = ea * eb;
        return (eo == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int model_lat(input logic [1:0] o);
        return (MULX && o != 2'b00) ? 7 : 6;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op at cycle T; optionally pulse start again at cycle T+inject_c.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string nm, input int inject_c);
        int          lat;
        int          done_at;
        int          ndone;
        int          busy_bad;
        logic [31:0] res_at;
        lat      = model_lat(o);
        done_at  = -1;
        ndone    = 0;
        busy_bad = 0;
        res_at   = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        src1  = $urandom;
        src2  = $urandom;
        for (int c = 1; c <= lat + 1; c++) begin
            if (busy !== (c <= lat)) busy_bad++;
            if (done === 1'b1) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = c;
                    res_at  = result;
                end
            end
            if (c == inject_c) begin
                start = 1'b1;
                src1  = 32'h1234_5678;
                src2  = 32'h9ABC_DEF1;
            end else begin
                start = 1'b0;
            end
            if (c <= lat) begin
                @(posedge clk);
                #1;
            end
        end
        chk({nm, " done_cycle"}, 64'(done_at), 64'(lat));
        chk({nm, " done_count"}, 64'(ndone), 64'd1);
        chk({nm, " busy_profile"}, 64'(busy_bad), 64'd0);
        chk({nm, " result"}, {32'h0, res_at}, {32'h0, exp});
        chk({nm, " result_hold"}, {32'h0, result}, {32'h0, exp});
        last_res = exp;
    endtask

    vec_t vecs[9];

    initial begin
        int          ndone;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 32'h000B_000F};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3] = '{2'b11, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0000_0000};
        vecs[4] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[5] = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[6] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[7] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[8] = '{2'b10, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1};

        reset = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        op    = 2'b00;
        src1  = 32'h0;
        src2  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", {63'h0, busy}, 64'd0);
        chk("reset done", {63'h0, done}, 64'd0);
        chk("reset result", {32'h0, result}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b,
                  MULX ? vecs[i].exp_mulx : vecs[i].exp_lo, $sformatf("vec%0d", i), 0);
        end

        // Kill at T+3 of a MULXUU, then a MUL started at T+4.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        src1  = 32'h0000_0007;
        src2  = 32'h0000_0009;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        kill = 1'b1;
        chk("kill busy_at_T3", {63'h0, busy}, 64'd1);
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill busy_at_T4", {63'h0, busy}, 64'd0);
        chk("kill done_at_T4", {63'h0, done}, 64'd0);
        chk("kill result_held", {32'h0, result}, {32'h0, last_res});
        do_op(2'b00, 32'h0000_1234, 32'h0001_0001, 32'h1234_1234, "after_kill", 0);

        // Start pulsed at T+2 while busy must be ignored.
        do_op(2'b00, 32'h0003_0002, 32'h0000_0011, 32'h0033_0022, "busy_start", 2);

        // Asynchronous reset at T+4 of a MULXSS.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        src1  = 32'hFFFF_FFF0;
        src2  = 32'h0000_0100;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        chk("midreset busy", {63'h0, busy}, 64'd0);
        chk("midreset done", {63'h0, done}, 64'd0);
        chk("midreset result", {32'h0, result}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        chk("midreset no_done", 64'(ndone), 64'd0);
        last_res = 32'h0;
        do_op(2'b10, 32'hFFFF_FFF0, 32'h0000_0100, model(2'b10, 32'hFFFF_FFF0, 32'h0000_0100),
              "after_reset", 0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = rand_operand();
            rb = rand_operand();
            do_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rand%0d op%0d", i, ro), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
